// File: rtl/amba3_apb_mem_slave.sv
// AMBA 3 APB completer over a word-addressed register memory.
// Wait states are programmable per transfer; illegal accesses complete with PSLVERR.
module amba3_apb_mem_slave #(
  parameter int                    ADDR_SIZE = 32,
  parameter int                    DATA_SIZE = 32,
  parameter int                    MEM_DEPTH = 256,
  parameter logic [ADDR_SIZE-1:0]  BASE_ADDR = '0
) (
  input  logic                 pclk,
  input  logic                 preset_n,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [ADDR_SIZE-1:0] paddr,
  input  logic [DATA_SIZE-1:0] pwdata,
  input  logic [3:0]           wait_cfg,
  output logic [DATA_SIZE-1:0] prdata,
  output logic                 pready,
  output logic                 pslverr,
  output logic                 state_dbg
);

  localparam int DATA_BASE = $clog2(DATA_SIZE / 8);
  localparam int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = ADDR_SIZE'((1 << DATA_BASE) - 1);
  localparam logic [ADDR_SIZE-1:0] DEPTH_A    = ADDR_SIZE'(MEM_DEPTH);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t               state;
  logic [3:0]           cnt;
  logic                 wr_q;
  logic                 ill_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_SIZE-1:0] rdata_q;
  logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

  // Address decode of the current bus address; the extra MSB of diff is the
  // borrow, i.e. paddr lies below BASE_ADDR.
  logic [ADDR_SIZE:0]   diff;
  logic [ADDR_SIZE-1:0] idx_full;
  logic [IDX_W-1:0]     idx_now;
  logic                 ill_now;
  logic                 done;

  assign diff     = {1'b0, paddr} - {1'b0, BASE_ADDR};
  assign idx_full = diff[ADDR_SIZE-1:0] >> DATA_BASE;
  assign idx_now  = idx_full[IDX_W-1:0];
  assign ill_now  = ((paddr & ALIGN_MASK) != '0) || diff[ADDR_SIZE] || (idx_full >= DEPTH_A);

  // Handshake: a transfer is accepted when psel & ~penable is sampled (setup),
  // and completes on the first edge where psel & penable & pready all hold.
  assign done = (state == ACCESS) && psel && penable && (cnt == 4'd0);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      ill_q   <= 1'b0;
      idx_q   <= '0;
      rdata_q <= '0;
    end else if (psel && !penable) begin
      // Setup from IDLE, or abort-plus-new-setup from ACCESS.
      state   <= ACCESS;
      wr_q    <= pwrite;
      idx_q   <= idx_now;
      ill_q   <= ill_now;
      cnt     <= wait_cfg;
      rdata_q <= (!pwrite && !ill_now) ? mem[idx_now] : '0;
    end else if (state == IDLE) begin
      if (psel) begin
        // Access phase without a setup: finish immediately with an error.
        state <= ACCESS;
        wr_q  <= pwrite;
        ill_q <= 1'b1;
        cnt   <= 4'd0;
      end
    end else if (!psel) begin
      state   <= IDLE;
      rdata_q <= '0;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end else begin
      state   <= IDLE;
      rdata_q <= '0;
    end
  end

  // Storage is deliberately not reset; only legal writes commit, at completion.
  always_ff @(posedge pclk) begin
    if (preset_n && done && wr_q && !ill_q)
      mem[idx_q] <= pwdata;
  end

  assign pready    = (state == ACCESS) && (cnt == 4'd0);
  assign pslverr   = pready && ill_q;
  assign prdata    = ill_q ? '0 : rdata_q;
  assign state_dbg = (state == ACCESS);

endmodule

// File: tb/tb_amba3_apb_mem_slave.sv
// Self-checking bench for amba3_apb_mem_slave: directed scenarios plus
// randomized traffic against an address-level memory model.
module tb_amba3_apb_mem_slave;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0;

  logic        pclk     = 1'b0;
  logic        preset_n = 1'b0;
  logic        psel     = 1'b0;
  logic        penable  = 1'b0;
  logic        pwrite   = 1'b0;
  logic [31:0] paddr    = '0;
  logic [31:0] pwdata   = '0;
  logic [3:0]  wait_cfg = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        state_dbg;

  int checks   = 0;
  int failures = 0;

  // Reference model: word index -> last legally written data.
  logic [31:0] ref_mem [int];

  amba3_apb_mem_slave #(
    .ADDR_SIZE(32), .DATA_SIZE(32), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .wait_cfg(wait_cfg),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .state_dbg(state_dbg)
  );

  always #5 pclk = ~pclk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic bit ref_legal(input logic [31:0] a);
    longint d;
    d = longint'(a) - longint'(BASE);
    return (d >= 0) && (d % 4 == 0) && (d / 4 < DEPTH);
  endfunction

  function automatic int ref_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Runs one transfer starting just after a rising edge; returns just after the
  // completion edge. lat counts cycles from setup edge to the pready cycle (-1 on timeout).
  task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] nwait, input bit violate,
                          output logic [31:0] rd, output logic err, output int lat);
    bit seen;
    psel = 1'b1; penable = violate; pwrite = wr; paddr = addr; pwdata = data; wait_cfg = nwait;
    @(posedge pclk); #1;
    penable  = 1'b1;
    wait_cfg = 4'($urandom);
    lat = 0; seen = 1'b0; rd = 'x; err = 1'bx;
    while (!seen && lat < 40) begin
      @(negedge pclk);
      lat++;
      if (pready === 1'b1) begin
        seen = 1'b1; rd = prdata; err = pslverr;
      end
    end
    if (!seen) lat = -1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] rd; logic err; int lat;
    preset_n = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    checks++; if (pready !== 1'b0) begin failures++; $display("FAIL reset_pready: got %b expected 0", pready); end
    checks++; if (pslverr !== 1'b0) begin failures++; $display("FAIL reset_pslverr: got %b expected 0", pslverr); end
    checks++; if (prdata !== 32'h0) begin failures++; $display("FAIL reset_prdata: got %h expected 0", prdata); end
    @(negedge pclk); preset_n = 1'b1;
    @(posedge pclk); #1;

    apb_xfer(1'b1, 32'h018, 32'h1234ABCD, 4'd0, 1'b0, rd, err, lat);
    ref_mem[ref_idx(32'h018)] = 32'h1234ABCD;
    checks++; if (err !== 1'b0 || lat != 1) begin failures++; $display("FAIL reset_prewrite: got err=%b lat=%0d expected err=0 lat=1", err, lat); end

    // Pending write with wait_cfg=5, reset asserted during its ready cycle.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h018; pwdata = 32'hDEAD0000; wait_cfg = 4'd5;
    @(posedge pclk); #1;
    penable = 1'b1;
    repeat (5) @(posedge pclk);
    #1;
    checks++; if (pready !== 1'b1) begin failures++; $display("FAIL reset_mid_ready: got %b expected 1", pready); end
    #2 preset_n = 1'b0;
    #1;
    checks++; if (pready !== 1'b0) begin failures++; $display("FAIL reset_async_pready: got %b expected 0", pready); end
    checks++; if (pslverr !== 1'b0) begin failures++; $display("FAIL reset_async_pslverr: got %b expected 0", pslverr); end
    checks++; if (prdata !== 32'h0) begin failures++; $display("FAIL reset_async_prdata: got %h expected 0", prdata); end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk); preset_n = 1'b1;
    @(posedge pclk); #1;

    apb_xfer(1'b0, 32'h018, 32'h0, 4'd0, 1'b0, rd, err, lat);
    checks++; if (rd !== ref_mem[ref_idx(32'h018)]) begin failures++; $display("FAIL reset_no_write: got %h expected %h", rd, ref_mem[ref_idx(32'h018)]); end
  endtask

  task automatic test_zero_wait;
    logic [31:0] addrs [3];
    logic [31:0] datas [3];
    logic [31:0] rd; logic err; int lat;
    addrs = '{32'h040, 32'h084, 32'h0C0};
    datas = '{32'h80003333, 32'h04400011, 32'h0000001C};
    for (int i = 0; i < 3; i++) begin
      apb_xfer(1'b1, addrs[i], datas[i], 4'd0, 1'b0, rd, err, lat);
      ref_mem[ref_idx(addrs[i])] = datas[i];
      checks++; if (err !== 1'b0 || lat != 1) begin failures++; $display("FAIL zw_write[%0d]: got err=%b lat=%0d expected err=0 lat=1", i, err, lat); end
    end
    for (int i = 0; i < 3; i++) begin
      apb_xfer(1'b0, addrs[i], 32'h0, 4'd0, 1'b0, rd, err, lat);
      checks++; if (rd !== datas[i] || err !== 1'b0 || lat != 1) begin
        failures++; $display("FAIL zw_read[%0d]: got data=%h err=%b lat=%0d expected data=%h err=0 lat=1", i, rd, err, lat, datas[i]);
      end
    end
  endtask

  task automatic test_wait_states;
    logic [31:0] rd; logic err; int lat;
    apb_xfer(1'b1, 32'h018, 32'h22446688, 4'd3, 1'b0, rd, err, lat);
    ref_mem[ref_idx(32'h018)] = 32'h22446688;
    checks++; if (lat != 4 || err !== 1'b0) begin failures++; $display("FAIL ws_write: got lat=%0d err=%b expected lat=4 err=0", lat, err); end
    apb_xfer(1'b0, 32'h018, 32'h0, 4'd3, 1'b0, rd, err, lat);
    checks++; if (lat != 4) begin failures++; $display("FAIL ws_read_lat: got %0d expected 4", lat); end
    checks++; if (rd !== 32'h22446688) begin failures++; $display("FAIL ws_read_data: got %h expected 22446688", rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic err; int lat;
    apb_xfer(1'b1, 32'h041, 32'hFFFFFFFF, 4'd0, 1'b0, rd, err, lat);
    checks++; if (err !== 1'b1 || lat != 1) begin failures++; $display("FAIL err_unaligned: got err=%b lat=%0d expected err=1 lat=1", err, lat); end
    apb_xfer(1'b1, 32'h400, 32'hFFFFFFFF, 4'd2, 1'b0, rd, err, lat);
    checks++; if (err !== 1'b1 || lat != 3) begin failures++; $display("FAIL err_range: got err=%b lat=%0d expected err=1 lat=3", err, lat); end
    apb_xfer(1'b0, 32'h040, 32'h0, 4'd0, 1'b0, rd, err, lat);
    checks++; if (rd !== 32'h80003333 || err !== 1'b0) begin failures++; $display("FAIL err_intact: got data=%h err=%b expected data=80003333 err=0", rd, err); end
    apb_xfer(1'b0, 32'h400, 32'h0, 4'd0, 1'b0, rd, err, lat);
    checks++; if (rd !== 32'h0 || err !== 1'b1) begin failures++; $display("FAIL err_read_range: got data=%h err=%b expected data=0 err=1", rd, err); end
  endtask

  task automatic test_abort;
    logic [31:0] rd; logic err; int lat;
    bit seen;
    seen = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h018; pwdata = 32'hBAADF00D; wait_cfg = 4'd4;
    @(posedge pclk); #1;
    penable = 1'b1;
    repeat (2) begin
      @(negedge pclk); if (pready !== 1'b0) seen = 1'b1;
      @(posedge pclk); #1;
    end
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk); if (pready !== 1'b0) seen = 1'b1;
    checks++; if (seen) begin failures++; $display("FAIL abort_pready: got pready=1 during aborted transfer expected 0"); end
    @(posedge pclk); #1;
    checks++; if (state_dbg !== 1'b0) begin failures++; $display("FAIL abort_idle: got state=%b expected 0", state_dbg); end
    apb_xfer(1'b0, 32'h018, 32'h0, 4'd1, 1'b0, rd, err, lat);
    checks++; if (rd !== ref_mem[ref_idx(32'h018)] || lat != 2) begin
      failures++; $display("FAIL abort_no_write: got data=%h lat=%0d expected data=%h lat=2", rd, lat, ref_mem[ref_idx(32'h018)]);
    end
  endtask

  task automatic test_protocol_violation;
    logic [31:0] rd; logic err; int lat;
    apb_xfer(1'b0, 32'h040, 32'h0, 4'd7, 1'b1, rd, err, lat);
    checks++; if (lat != 1 || err !== 1'b1 || rd !== 32'h0) begin
      failures++; $display("FAIL violation: got lat=%0d err=%b data=%h expected lat=1 err=1 data=0", lat, err, rd);
    end
    @(negedge pclk);
    checks++; if (pready !== 1'b0) begin failures++; $display("FAIL violation_release: got pready=%b expected 0", pready); end
    @(posedge pclk); #1;
  endtask

  task automatic test_random;
    logic [31:0] rd; logic err; int lat;
    logic [31:0] a, d;
    logic [3:0]  w;
    int bad_wr, bad_rd;
    bad_wr = 0; bad_rd = 0;
    for (int n = 0; n < 1000; n++) begin
      a = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2);
      d = $urandom;
      w = 4'($urandom_range(0, 15));
      apb_xfer(1'b1, a, d, w, 1'b0, rd, err, lat);
      if (ref_legal(a)) ref_mem[ref_idx(a)] = d;
      checks++; if (err !== 1'b0 || lat != int'(w) + 1) begin
        failures++; bad_wr++;
        if (bad_wr <= 10) $display("FAIL rand_write[%0d] addr=%h: got err=%b lat=%0d expected err=0 lat=%0d", n, a, err, lat, int'(w) + 1);
      end
      repeat ($urandom_range(0, 10)) begin @(posedge pclk); #1; end
    end
    foreach (ref_mem[k]) begin
      a = BASE + (32'(k) << 2);
      w = 4'($urandom_range(0, 3));
      apb_xfer(1'b0, a, 32'h0, w, 1'b0, rd, err, lat);
      checks++; if (rd !== ref_mem[k] || err !== 1'b0 || lat != int'(w) + 1) begin
        failures++; bad_rd++;
        if (bad_rd <= 10) $display("FAIL rand_read addr=%h: got data=%h err=%b lat=%0d expected data=%h err=0 lat=%0d", a, rd, err, lat, ref_mem[k], int'(w) + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_errors();
    test_abort();
    test_protocol_violation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
